// File: rtl/div_iter_unit_if.sv
// div_iter_unit_if: request/response bundle between the EX-stage issuer and the iterative divider
// master: drives div_en, a, b, signed_op, rem_op, cancel; receives result, ready, stallreq_for_div
// slave:  the divider side of the same signals
interface div_iter_unit_if #(parameter int XLEN = 32) ();
    logic            div_en;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            signed_op;
    logic            rem_op;
    logic            cancel;
    logic [XLEN-1:0] result;
    logic            ready;
    logic            stallreq_for_div;
    modport master (
        output div_en, a, b, signed_op, rem_op, cancel,
        input  result, ready, stallreq_for_div
    );
    modport slave (
        input  div_en, a, b, signed_op, rem_op, cancel,
        output result, ready, stallreq_for_div
    );
endinterface

// File: rtl/div_iter_unit.sv
// div_iter_unit: iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU
// clk, rst        : clock, synchronous active-high reset
// bus.div_en/a/b  : start pulse and operands (sampled only in IDLE)
// bus.signed_op   : signed operation; bus.rem_op: return remainder instead of quotient
// bus.cancel      : pipeline flush, aborts to IDLE without a result
// bus.result      : registered result; bus.ready: one-cycle valid pulse
// bus.stallreq_for_div : pipeline stall request while the divide is in flight
module div_iter_unit #(
    parameter int XLEN = 32
) (
    input logic           clk,
    input logic           rst,
    div_iter_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          state, state_nx;
    logic [XLEN-1:0] rem, quo, dmag, res_r;
    logic [CW-1:0]   count;
    logic            sgn, remsel, a_neg, b_neg;
    logic            start, ovf, special, last;
    logic [XLEN-1:0] a_mag, b_mag, spec_res, rem_nx, quo_nx, q_fix, r_fix;
    logic [XLEN:0]   trial;
    always_comb begin
        start    = state == IDLE && bus.div_en && !bus.cancel;
        ovf      = bus.signed_op && bus.a == {1'b1, {(XLEN-1){1'b0}}} && bus.b == '1;
        special  = bus.b == '0 || ovf;
        a_mag    = (bus.signed_op && bus.a[XLEN-1]) ? -bus.a : bus.a;
        b_mag    = (bus.signed_op && bus.b[XLEN-1]) ? -bus.b : bus.b;
        spec_res = bus.b == '0 ? (bus.rem_op ? bus.a : '1)
                               : (bus.rem_op ? '0 : {1'b1, {(XLEN-1){1'b0}}});
        // {rem, quo} shifted left: the bit leaving quo enters the partial remainder
        trial    = {rem, quo[XLEN-1]} - {1'b0, dmag};
        rem_nx   = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
        quo_nx   = {quo[XLEN-2:0], !trial[XLEN]};
        q_fix    = (sgn && (a_neg ^ b_neg)) ? -quo_nx : quo_nx;
        r_fix    = (sgn && a_neg) ? -rem_nx : rem_nx;
        last     = count == CW'(XLEN-1);
        state_nx = bus.cancel     ? IDLE :
                   state == IDLE  ? (start ? (special ? DONE : RUN) : IDLE) :
                   state == RUN   ? (last ? DONE : RUN) : IDLE;
        bus.ready            = state == DONE && !bus.cancel;
        bus.stallreq_for_div = start || (state == RUN && !bus.cancel);
        bus.result           = res_r;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= '0;
            quo    <= '0;
            dmag   <= '0;
            res_r  <= '0;
            count  <= '0;
            sgn    <= 1'b0;
            remsel <= 1'b0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
        end else if (start) begin
            sgn    <= bus.signed_op;
            remsel <= bus.rem_op;
            a_neg  <= bus.signed_op && bus.a[XLEN-1];
            b_neg  <= bus.signed_op && bus.b[XLEN-1];
            rem    <= '0;
            quo    <= a_mag;
            dmag   <= b_mag;
            count  <= '0;
            if (special) res_r <= spec_res;
        end else if (state == RUN && !bus.cancel) begin
            rem   <= rem_nx;
            quo   <= quo_nx;
            count <= count + 1'b1;
            if (last) res_r <= remsel ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scoreboard bench for div_iter_unit against an arithmetic reference model
module tb_div_iter_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    div_iter_unit_if #(.XLEN(32)) ifc ();
    div_iter_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int n_ready = 0;
    int n_push = 0;
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic r);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return r ? a % b : a / b;
    endfunction
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        if (!rst && ifc.ready) begin
            n_ready++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: got result %h with no operation pending", ifc.result);
            end else begin
                check("result", ifc.result, exp_q.pop_front());
            end
        end
    end
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r);
        int lat;
        bit stall_bad;
        bit spec;
        spec = b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        @(posedge clk); #1;
        ifc.a = a; ifc.b = b; ifc.signed_op = s; ifc.rem_op = r; ifc.div_en = 1'b1;
        exp_q.push_back(ref_div(a, b, s, r));
        n_push++;
        @(negedge clk);
        check("stall_c0", 32'(ifc.stallreq_for_div), 32'd1);
        @(posedge clk); #1;
        ifc.div_en = 1'b0; ifc.a = $urandom; ifc.b = $urandom;
        ifc.signed_op = 1'($urandom); ifc.rem_op = 1'($urandom);
        lat = 1;
        stall_bad = 1'b0;
        while (lat <= 40) begin
            @(negedge clk);
            if (ifc.ready) break;
            if (!ifc.stallreq_for_div) stall_bad = 1'b1;
            lat++;
        end
        if (lat > 40) $display("FAIL timeout: no ready within 40 cycles for %h/%h", a, b);
        check("latency", 32'(lat), spec ? 32'd1 : 32'd33);
        check("stall_done", 32'(ifc.stallreq_for_div), 32'd0);
        check("stall_run", 32'(stall_bad), 32'd0);
    endtask
    task automatic issue_raw(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        ifc.a = a; ifc.b = b; ifc.signed_op = 1'b0; ifc.rem_op = 1'b0; ifc.div_en = 1'b1;
        @(posedge clk); #1;
        ifc.div_en = 1'b0;
    endtask
    initial begin
        logic [31:0] held, ra, rb;
        int lat;
        ifc.div_en = 1'b0; ifc.a = '0; ifc.b = '0;
        ifc.signed_op = 1'b0; ifc.rem_op = 1'b0; ifc.cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", ifc.result, 32'd0);
        check("rst_ready", 32'(ifc.ready), 32'd0);
        check("rst_stall", 32'(ifc.stallreq_for_div), 32'd0);
        run_op(32'd100, 32'd7, 1'b0, 1'b0);
        run_op(32'd100, 32'd7, 1'b0, 1'b1);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0, 1'b1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_op(32'd1000, 32'd7, 1'b0, 1'b0);
        held = ref_div(32'd1000, 32'd7, 1'b0, 1'b0);
        issue_raw(32'd1000, 32'd3);
        repeat (8) @(posedge clk);
        @(posedge clk); #1;
        ifc.cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", 32'(ifc.stallreq_for_div), 32'd0);
        check("cancel_ready", 32'(ifc.ready), 32'd0);
        @(posedge clk); #1;
        ifc.cancel = 1'b0;
        @(negedge clk);
        check("cancel_hold", ifc.result, held);
        run_op(32'd9, 32'd3, 1'b0, 1'b0);
        issue_raw(32'd5000, 32'd13);
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_result", ifc.result, 32'd0);
        check("midrst_ready", 32'(ifc.ready), 32'd0);
        check("midrst_stall", 32'(ifc.stallreq_for_div), 32'd0);
        @(posedge clk); #1;
        ifc.a = 32'd600; ifc.b = 32'd5; ifc.signed_op = 1'b0; ifc.rem_op = 1'b0; ifc.div_en = 1'b1;
        exp_q.push_back(ref_div(32'd600, 32'd5, 1'b0, 1'b0));
        n_push++;
        @(posedge clk); #1;
        ifc.div_en = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        ifc.a = 32'd1; ifc.b = 32'd1; ifc.div_en = 1'b1;
        @(posedge clk); #1;
        ifc.div_en = 1'b0;
        lat = 0;
        while (lat < 40 && !ifc.ready) begin
            @(negedge clk);
            lat++;
        end
        repeat (40) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                4: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom), 1'($urandom));
        end
        repeat (40) @(negedge clk);
        check("ready_count", 32'(n_ready), 32'(n_push));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
